sdf_r2_stage: RTL
=================

// Module: sdf_r2_stage
// PURPOSE
//  Parametrised radix-2 single-path delay-feedback (SDF) DIF butterfly stage.
//  Successor to the fixed 32-point stage-1 block. Generic delay depth D, so one
//  module serves every stage of an N-point pipeline. Adds stall support, twiddle
//  index/tag outputs for the downstream multiplier, and overflow reporting.
//  Sits between input streamer (or previous stage's twiddle mult) and next stage.
// PARAMETERS
//  DW     19  data width per real/imag component, two's complement
//  D      16  delay-line depth = N/2^(s+1); power of 2, >=1
//  LOG2D  4   log2(D); idx_o width (min 1 when D=1)
// PORTS
//  clk         in   1      clock, all logic on posedge
//  rst         in   1      synchronous reset, active-low
//  valid_i     in   1      input sample valid; also stage advance enable
//  data_in_r   in   DW     input real
//  data_in_i   in   DW     input imag
//  valid_o     out  1      output sample valid
//  data_out_r  out  DW     output real
//  data_out_i  out  DW     output imag
//  diff_o      out  1      1: output is a-b term (needs W^idx_o); 0: a+b term
//  idx_o       out  LOG2D  butterfly index k within half-block
//  ovf_o       out  1      sticky overflow flag
// BEHAVIOUR
//  - Reset (rst=0 at posedge): cnt=0, primed=0, delay line cleared to 0,
//    valid_o=0, data_out_r/i=0, diff_o=0, idx_o=0, ovf_o=0. Reset wins over valid_i.
//  - Accepted input = valid_i=1 at posedge. valid_i=0: all state frozen, valid_o=0,
//    data/diff/idx outputs hold last value.
//  - cnt: LOG2D+1 bits, mod 2D, +1 per accepted input; wraps 2D-1 -> 0.
//  - Delay line: D-entry complex shift register, shifts only on accepted input;
//    head = oldest entry.
//  - Phase 0 (cnt<D): write input to delay line; out = head (prior block's diff),
//    diff_o=1, idx_o=cnt[LOG2D-1:0].
//  - Phase 1 (cnt>=D): a=head, b=input; out = a+b, diff_o=0, idx_o=cnt-D;
//    write a-b into delay line.
//  - primed: set on accepted input with cnt=D-1. valid_o<=1 on accepted input
//    iff (cnt>=D or primed); else 0. primed cleared only by reset.
//  - All outputs registered. Sum k appears 1 cycle after b_k accepted. Diff k
//    appears 1 cycle after input k of next block accepted (D accepted samples
//    later). Last block's diffs need D further accepted inputs (zeros) to flush.
//  - Arithmetic: add/sub at DW+1 bits per component, reduced to DW bits (see
//    CONFIGURATION); same reduction for out and delay-line write.
//  - Simultaneous phase-1 wrap and reset: reset wins.
// CONFIGURATION
//  SDF_SCALE_EN defined: each DW+1 result -> (s+1)>>>1 (round half up),
//    always fits DW bits; ovf_o tied 0. Stage gain 1/2.
//  SDF_SCALE_EN undefined: keep low DW bits (wrap); ovf_o set, sticky until
//    reset, on any component of out or delay write outside DW range. Gain 1.
// TESTING  (DW=19, D=16 unless noted)
//  1 32x (100,0), then 16 zeros, valid_i=1 -> valid_o rises 17 cycles after first
//    input; 16x out=200,diff_o=0,idx 0..15; then 16x out=0,diff_o=1,idx 0..15.
//  2 Impulse x[0]=(4,-4), 31 zeros + 16 zeros -> sum0=(4,-4), diff0=(4,-4),
//    all else 0; with SDF_SCALE_EN: (2,-2) both.
//  3 x[0]=x[16]=(262143,0) no scale -> sum0 real=-2 (wrap), ovf_o=1 next cycle,
//    stays 1; with SDF_SCALE_EN sum0=262143, ovf_o=0.
//  4 Test 1 with valid_i=0 for 3 cycles at sample 20 -> identical output sequence,
//    valid_o=0 and outputs held during the 3 stall cycles.
//  5 rst=0 for 1 cycle after 10 inputs -> next cycle all outputs 0; restart
//    behaves as test 1 (no stale data, valid_o again after 17 inputs).
//  6 D=1, inputs 1,2,3,4 (real) -> outs 3(diff 0), -1(diff 1), 7(diff 0), then
//    -1 after one flush input.

Source files
------------

// File: rtl/sdf_r2_stage.sv
// Radix-2 single-path delay-feedback DIF butterfly stage with generic delay depth D.
// Optional build macro SDF_SCALE_EN: halve every butterfly result (round half up) instead of wrapping.
module sdf_r2_stage #(
  parameter int DW    = 19,
  parameter int D     = 16,
  parameter int LOG2D = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic signed [DW-1:0] data_in_r,
  input  logic signed [DW-1:0] data_in_i,
  output logic                 valid_o,
  output logic signed [DW-1:0] data_out_r,
  output logic signed [DW-1:0] data_out_i,
  output logic                 diff_o,
  output logic [LOG2D-1:0]     idx_o,
  output logic                 ovf_o
);

  localparam int CW = LOG2D + 1;

  // Brings a DW+1 bit butterfly result back to DW bits.
  function automatic logic signed [DW-1:0] reduce(input logic signed [DW:0] s);
`ifdef SDF_SCALE_EN
    logic signed [DW+1:0] t;
    t = {s[DW], s} + (DW+2)'(1);
    return t[DW:1];
`else
    return s[DW-1:0];
`endif
  endfunction

  // A DW+1 bit value fits DW bits exactly when its two top bits agree.
  function automatic logic out_of_range(input logic signed [DW:0] s);
    return s[DW] ^ s[DW-1];
  endfunction

  logic [CW-1:0]        r_cnt;
  logic                 r_primed;
  logic signed [DW-1:0] r_dl_r [D];
  logic signed [DW-1:0] r_dl_i [D];
  logic                 r_vld;
  logic signed [DW-1:0] r_out_r;
  logic signed [DW-1:0] r_out_i;
  logic                 r_diff;
  logic [LOG2D-1:0]     r_idx;
  logic                 r_ovf;

  logic                 w_ph1;
  logic [CW-1:0]        w_idx;
  logic signed [DW-1:0] w_head_r;
  logic signed [DW-1:0] w_head_i;
  logic signed [DW:0]   w_sum_r;
  logic signed [DW:0]   w_sum_i;
  logic signed [DW:0]   w_dif_r;
  logic signed [DW:0]   w_dif_i;
  logic signed [DW-1:0] w_out_r;
  logic signed [DW-1:0] w_out_i;
  logic signed [DW-1:0] w_wr_r;
  logic signed [DW-1:0] w_wr_i;
  logic                 w_ovf;

  assign w_ph1    = (r_cnt >= CW'(D));
  assign w_idx    = w_ph1 ? (r_cnt - CW'(D)) : r_cnt;
  assign w_head_r = r_dl_r[D-1];
  assign w_head_i = r_dl_i[D-1];

  assign w_sum_r = {w_head_r[DW-1], w_head_r} + {data_in_r[DW-1], data_in_r};
  assign w_sum_i = {w_head_i[DW-1], w_head_i} + {data_in_i[DW-1], data_in_i};
  assign w_dif_r = {w_head_r[DW-1], w_head_r} - {data_in_r[DW-1], data_in_r};
  assign w_dif_i = {w_head_i[DW-1], w_head_i} - {data_in_i[DW-1], data_in_i};

  // First half of a block forwards the previous block's stored differences and
  // parks the new sample; second half emits sums and parks differences.
  assign w_out_r = w_ph1 ? reduce(w_sum_r) : w_head_r;
  assign w_out_i = w_ph1 ? reduce(w_sum_i) : w_head_i;
  assign w_wr_r  = w_ph1 ? reduce(w_dif_r) : data_in_r;
  assign w_wr_i  = w_ph1 ? reduce(w_dif_i) : data_in_i;
  assign w_ovf   = w_ph1 & (out_of_range(w_sum_r) | out_of_range(w_sum_i) |
                            out_of_range(w_dif_r) | out_of_range(w_dif_i));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_primed <= 1'b0;
      r_vld    <= 1'b0;
      r_out_r  <= '0;
      r_out_i  <= '0;
      r_diff   <= 1'b0;
      r_idx    <= '0;
      r_ovf    <= 1'b0;
      for (int i = 0; i < D; i++) begin
        r_dl_r[i] <= '0;
        r_dl_i[i] <= '0;
      end
    end else if (valid_i) begin
      r_cnt <= (r_cnt == CW'(2*D-1)) ? '0 : r_cnt + CW'(1);
      if (r_cnt == CW'(D-1)) r_primed <= 1'b1;
      r_vld   <= w_ph1 | r_primed;
      r_out_r <= w_out_r;
      r_out_i <= w_out_i;
      r_diff  <= ~w_ph1;
      r_idx   <= w_idx[LOG2D-1:0];
      r_ovf   <= r_ovf | w_ovf;
      for (int i = D-1; i > 0; i--) begin
        r_dl_r[i] <= r_dl_r[i-1];
        r_dl_i[i] <= r_dl_i[i-1];
      end
      r_dl_r[0] <= w_wr_r;
      r_dl_i[0] <= w_wr_i;
    end else begin
      r_vld <= 1'b0;
    end
  end

  assign valid_o    = r_vld;
  assign data_out_r = r_out_r;
  assign data_out_i = r_out_i;
  assign diff_o     = r_diff;
  assign idx_o      = r_idx;
`ifdef SDF_SCALE_EN
  assign ovf_o = 1'b0;
`else
  assign ovf_o = r_ovf;
`endif

endmodule
